icache_resp_unit: RTL
=====================

Name: icache_resp_unit

Overview:
- Responder side of the fetch/ICache request protocol. Accepts 2-instruction fetch requests from prefetch (req/addr), returns addr_ok per accepted request, then exactly one data_ok pulse carrying the 64-bit fetch pair in request order.
- Sits between the prefetch/fetch stages and a variable-latency, in-order backing memory port.
- Holds up to DEPTH outstanding requests.
- Never cancels a response; fetch discards post-flush responses itself.

Parameters:
- DEPTH, 4, max accepted-but-not-returned requests (power of 2, ≥2).
- CNT_W, $clog2(DEPTH)+1, width of outstanding counter.

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  prefetch fetch request valid.
- addr  input  32  fetch address; addr[2:0] ignored (8-byte aligned pair).
- addr_ok  output  1  request accepted this cycle (combinational).
- data_ok  output  1  registered; response valid, one cycle per request.
- rdata1  output  32  instruction at {addr[31:3],3'b000}.
- rdata2  output  32  instruction at {addr[31:3],3'b100}.
- mem_req  output  1  backing memory request valid.
- mem_addr  output  32  {addr[31:3],3'b000}.
- mem_gnt  input  1  memory accepts mem_req this cycle.
- mem_rvalid  input  1  memory read data valid, strictly in order.
- mem_rdata  input  64  [31:0]=rdata1 word, [63:32]=rdata2 word.

Behaviour:
- Reset values: addr_ok=0 (req ignored during reset), data_ok=0, rdata1=rdata2=0, mem_req=0, outstanding count=0, line buffer invalid.
- Acceptance:
  - mem_req = req && (count < DEPTH).
  - addr_ok = mem_req && mem_gnt.
  - mem_addr passes addr with low 3 bits cleared.
  - Zero-cycle acceptance; req may drop without addr_ok (no obligation to hold).
- Counter: count_next = count + addr_ok − mem_rvalid.
  - Simultaneous accept+return leaves count unchanged.
  - count == DEPTH forces mem_req=0.
  - mem_rvalid with count==0 is a protocol error: ignored, no data_ok, count stays 0; assertion fires in simulation.
- Response path, latency 1 cycle after mem_rvalid: data_ok<=1, rdata1<=mem_rdata[31:0], rdata2<=mem_rdata[63:32].
  - Otherwise data_ok<=0; rdata holds its last value.
- Ordering: responses are in acceptance order (memory is in-order). Minimum total latency addr_ok→data_ok is 2 cycles (mem_rvalid one cycle after gnt earliest).
- Fetch has no backpressure on data_ok. The unit never stalls responses and needs no response buffer.
- State machine over outstanding: EMPTY (count==0), PARTIAL, FULL (count==DEPTH). Transitions follow count_next only.
- Reset mid-transaction: all outstanding are dropped. Any mem_rvalid arriving after reset hits count==0 and is ignored (see above). The memory side is reset by the same signal.

Optional Feature:
- Macro ICACHE_RESP_LINEBUF_EN.
- Defined:
  - One-entry line buffer {valid, tag[31:3], data[63:0]} is loaded on every mem_rvalid, tagged with the address of the returning request. This requires a DEPTH-entry address FIFO, pushed on addr_ok and popped on mem_rvalid.
  - When req && count==0 && buffer valid && tag==addr[31:3]: addr_ok=1, mem_req=0, count unchanged, data_ok=1 next cycle with buffer data.
  - Hits are only allowed at count==0, so ordering is preserved.
  - Reset invalidates the buffer.
- Undefined: no buffer and no address FIFO; every request goes to memory.

Test Plan:
- Single request: reset, req addr=0xBFC0_0004, mem_gnt=1, mem_rvalid 3 cycles later with rdata=0x2222_2222_1111_1111 → mem_addr=0xBFC0_0000, addr_ok 1 cycle, data_ok 1 cycle after rvalid, rdata1=0x1111_1111, rdata2=0x2222_2222.
- Fill: req held high, mem_gnt=1, no rvalid → exactly DEPTH=4 addr_ok pulses, then mem_req=0; one mem_rvalid → mem_req reasserts the next cycle.
- Simultaneous accept and return at count=2 → count stays 2; 4 returns produce 4 data_ok in request order with matching data.
- mem_gnt=0 for 5 cycles with req high → addr_ok=0, count=0, no data_ok.
- Reset asserted with count=3, then stray mem_rvalid → no data_ok, count 0, assertion flagged.
- (ICACHE_RESP_LINEBUF_EN) fetch 0x8000_0000, drain, re-request 0x8000_0004 → addr_ok, mem_req=0, data_ok next cycle with same data. Re-request while count=1 → goes to memory.

Source files
------------

// File: rtl/icache_resp_unit.sv
// Fetch-side ICache responder: accepts fetch-pair requests, forwards them to an in-order memory port
// and returns one data_ok per accepted request. Optional line buffer under ICACHE_RESP_LINEBUF_EN.
module icache_resp_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] addr,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              not_full_c, empty_c;
  logic              hit_c, mem_acc_c, rvalid_ok_c, proto_err_c;
  logic [63:0]       resp_data_c;
  logic [2:0]        unused_addr_bits;

  assign unused_addr_bits = addr[2:0];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state follows the next outstanding count
  always_comb begin
    count_d = count_q + CNT_W'(mem_acc_c) - CNT_W'(rvalid_ok_c);
    state_d = ST_PARTIAL;
    if (count_d == '0)
      state_d = ST_EMPTY;
    else if (count_d == CNT_W'(DEPTH))
      state_d = ST_FULL;
  end

  // Output decode of the occupancy state
  always_comb begin
    not_full_c = 1'b1;
    empty_c    = 1'b0;
    case (state_q)
      ST_EMPTY: empty_c    = 1'b1;
      ST_FULL:  not_full_c = 1'b0;
      default:  ;
    endcase
  end

  assign mem_req     = !reset && req && not_full_c && !hit_c;
  assign mem_acc_c   = mem_req && mem_gnt;
  assign addr_ok     = mem_acc_c || hit_c;
  assign mem_addr    = {addr[31:3], 3'b000};
  assign rvalid_ok_c = !reset && mem_rvalid && !empty_c;
  assign proto_err_c = !reset && mem_rvalid && empty_c;

`ifdef ICACHE_RESP_LINEBUF_EN
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [28:0]      tag_fifo [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic             lb_valid_q;
  logic [28:0]      lb_tag_q;
  logic [63:0]      lb_data_q;

  assign hit_c       = !reset && req && empty_c && lb_valid_q && (lb_tag_q == addr[31:3]);
  assign resp_data_c = hit_c ? lb_data_q : mem_rdata;

  // Address FIFO tracks which request each in-order return belongs to
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      lb_valid_q <= 1'b0;
      lb_tag_q   <= '0;
      lb_data_q  <= '0;
    end else begin
      if (mem_acc_c) begin
        tag_fifo[wr_ptr_q] <= addr[31:3];
        wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
      end
      if (rvalid_ok_c) begin
        rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
        lb_valid_q <= 1'b1;
        lb_tag_q   <= tag_fifo[rd_ptr_q];
        lb_data_q  <= mem_rdata;
      end
    end
  end
`else
  assign hit_c       = 1'b0;
  assign resp_data_c = mem_rdata;
`endif

  // Response register, one cycle after the return (or a buffer hit)
  always_ff @(posedge clk) begin
    if (reset) begin
      data_ok <= 1'b0;
      rdata1  <= '0;
      rdata2  <= '0;
    end else begin
      data_ok <= rvalid_ok_c || hit_c;
      if (rvalid_ok_c || hit_c) begin
        rdata1 <= resp_data_c[31:0];
        rdata2 <= resp_data_c[63:32];
      end
    end
  end

  // A return with nothing outstanding is dropped; flag it in simulation
  always_ff @(posedge clk) begin
    if (!reset)
      assert (!proto_err_c)
        else $warning("icache_resp_unit: mem_rvalid with no outstanding request ignored");
  end

endmodule
